// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: opcode encoding, widths, default latencies.
// Optional feature macro: MULDIV_MADD_EN enables the madd/maddu/msub/msubu family.
package md_pkg;

   localparam int unsigned MD_OP_W    = 4;
   localparam int unsigned MD_CNT_W   = 5;
   localparam int unsigned MD_DATA_W  = 32;

   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
   localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
   localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

   // Divide-class ops take the longer latency.
   function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Ops that occupy the unit for a fixed number of cycles.
   function automatic logic md_is_timed(input logic [MD_OP_W-1:0] op);
      logic timed;
      timed = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MULDIV_MADD_EN
      timed = timed || (op == MD_MADD) || (op == MD_MADDU) ||
              (op == MD_MSUB) || (op == MD_MSUBU);
`endif
      return timed;
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational datapath: 64-bit HI:LO result for a timed multiply/divide op.
// Optional feature macro: MULDIV_MADD_EN adds the accumulate/subtract ops.
module muldiv_core
   import md_pkg::*;
(
   input  logic [MD_OP_W-1:0]   op,
   input  logic [MD_DATA_W-1:0] a,
   input  logic [MD_DATA_W-1:0] b,
   input  logic [MD_DATA_W-1:0] hi,
   input  logic [MD_DATA_W-1:0] lo,
   output logic [63:0]          pend
);

   logic [63:0]          prod_s;
   logic [63:0]          prod_u;
   logic                 div_s;
   logic [MD_DATA_W-1:0] a_mag;
   logic [MD_DATA_W-1:0] b_mag;
   logic [MD_DATA_W-1:0] num;
   logic [MD_DATA_W-1:0] den;
   logic [MD_DATA_W-1:0] quo;
   logic [MD_DATA_W-1:0] rem;
   logic [MD_DATA_W-1:0] quo_fix;
   logic [MD_DATA_W-1:0] rem_fix;

   // Products modulo 2^64; sign-extending first yields the signed product.
   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
   end

   // Divide on magnitudes, then fix signs; INT_MIN / -1 falls out as INT_MIN rem 0.
   always_comb begin
      div_s   = (op == MD_DIV);
      a_mag   = a[31] ? 32'(-a) : a;
      b_mag   = b[31] ? 32'(-b) : b;
      num     = div_s ? a_mag : a;
      den     = div_s ? b_mag : b;
      if (den == 32'd0) begin
         den = 32'd1;
      end
      quo     = num / den;
      rem     = num % den;
      quo_fix = (div_s && (a[31] ^ b[31])) ? 32'(-quo) : quo;
      rem_fix = (div_s && a[31]) ? 32'(-rem) : rem;
   end

   // Result select; divide by zero holds the current HI:LO.
   always_comb begin
      pend = {hi, lo};
      case (op)
         MD_MULT:  pend = prod_s;
         MD_MULTU: pend = prod_u;
         MD_DIV,
         MD_DIVU: begin
            if (b != 32'd0) begin
               pend = {rem_fix, quo_fix};
            end
         end
`ifdef MULDIV_MADD_EN
         MD_MADD:  pend = {hi, lo} + prod_s;
         MD_MADDU: pend = {hi, lo} + prod_u;
         MD_MSUB:  pend = {hi, lo} - prod_s;
         MD_MSUBU: pend = {hi, lo} - prod_u;
`endif
         default:  pend = {hi, lo};
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Optional feature macro: MULDIV_MADD_EN enables madd/maddu/msub/msubu.
module muldiv_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MD_OP_W-1:0]   md_op,
   input  logic [MD_DATA_W-1:0] a,
   input  logic [MD_DATA_W-1:0] b,
   output logic                 busy,
   output logic                 md_stall,
   output logic [MD_DATA_W-1:0] hi,
   output logic [MD_DATA_W-1:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [MD_CNT_W-1:0] cnt;
   logic [63:0]         pend;
   logic [63:0]         core_pend;
   logic                op_timed;

   muldiv_core u_core (
      .op   (md_op),
      .a    (a),
      .b    (b),
      .hi   (hi),
      .lo   (lo),
      .pend (core_pend)
   );

   // Hazard-unit stall covers the issue cycle as well as the busy window.
   always_comb begin
      op_timed = md_is_timed(md_op);
      md_stall = busy | (start & op_timed);
   end

   // Issue, countdown and commit; starts while busy are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         pend  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && op_timed) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  cnt   <= md_is_div(md_op) ? MD_CNT_W'(DIV_CYCLES)
                                            : MD_CNT_W'(MULT_CYCLES);
                  pend  <= core_pend;
               end else if (start && (md_op == MD_MTHI)) begin
                  hi <= a;
               end else if (start && (md_op == MD_MTLO)) begin
                  lo <= a;
               end
            end
            RUN: begin
               if (cnt == MD_CNT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  hi    <= pend[63:32];
                  lo    <= pend[31:0];
               end else begin
                  cnt <= cnt - MD_CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (default latencies 5/10).
// Optional feature macro: MULDIV_MADD_EN selects the accumulate expectations.
module tb_muldiv_unit;
   import md_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int pass_cnt = 0;
   int total    = 0;

   muldiv_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .md_stall (md_stall),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
      tick(); tick();
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else pass_cnt++;
      total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi); else pass_cnt++;
      total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo); else pass_cnt++;
      total++; if (md_stall !== 1'b0) $display("FAIL reset_stall got %0b exp 0", md_stall); else pass_cnt++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      int bad;
      // signed: -1 * 2 = -2; operands changed mid-run must not matter
      start = 1'b1; md_op = MD_MULT; a = 32'hFFFF_FFFF; b = 32'd2;
      #1;
      total++; if (md_stall !== 1'b1) $display("FAIL mult_stall_c0 got %0b exp 1", md_stall); else pass_cnt++;
      tick();
      start = 1'b0; md_op = MD_NONE; a = 32'd9; b = 32'd9;
      bad = 0;
      for (int c = 1; c <= 5; c++) begin
         if (busy !== 1'b1 || md_stall !== 1'b1 || hi !== 32'h0 || lo !== 32'h0) bad++;
         tick();
      end
      total++; if (bad != 0) $display("FAIL mult_busy_window bad_cycles %0d exp 0", bad); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL mult_busy_c6 got %0b exp 0", busy); else pass_cnt++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi); else pass_cnt++;
      total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL mult_lo got %h exp fffffffe", lo); else pass_cnt++;
      // unsigned: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
      start = 1'b1; md_op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'd2;
      tick();
      start = 1'b0; md_op = MD_NONE;
      for (int c = 1; c <= 5; c++) tick();
      total++; if (hi !== 32'h0000_0001) $display("FAIL multu_hi got %h exp 00000001", hi); else pass_cnt++;
      total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo got %h exp fffffffe", lo); else pass_cnt++;
   endtask

   task automatic test_div();
      int bad;
      // -7 / 2 = -3 rem -1
      start = 1'b1; md_op = MD_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
      tick();
      start = 1'b0; md_op = MD_NONE;
      bad = 0;
      for (int c = 1; c <= 10; c++) begin
         if (busy !== 1'b1 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) bad++;
         tick();
      end
      total++; if (bad != 0) $display("FAIL div_busy_window bad_cycles %0d exp 0", bad); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL div_busy_c11 got %0b exp 0", busy); else pass_cnt++;
      total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", lo); else pass_cnt++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", hi); else pass_cnt++;
      // divu by zero: full latency, HI/LO unchanged
      start = 1'b1; md_op = MD_DIVU; a = 32'd7; b = 32'd0;
      tick();
      start = 1'b0; md_op = MD_NONE;
      bad = 0;
      for (int c = 1; c <= 10; c++) begin
         if (busy !== 1'b1) bad++;
         tick();
      end
      total++; if (bad != 0) $display("FAIL divz_busy_window bad_cycles %0d exp 0", bad); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL divz_busy_end got %0b exp 0", busy); else pass_cnt++;
      total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
         $display("FAIL divz_hold got %h:%h exp ffffffff:fffffffd", hi, lo); else pass_cnt++;
      // signed overflow: INT_MIN / -1
      start = 1'b1; md_op = MD_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      tick();
      start = 1'b0; md_op = MD_NONE;
      for (int c = 1; c <= 10; c++) tick();
      total++; if (hi !== 32'h0 || lo !== 32'h8000_0000)
         $display("FAIL div_ovf got %h:%h exp 00000000:80000000", hi, lo); else pass_cnt++;
      // divu 100 / 7 = 14 rem 2
      start = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0; md_op = MD_NONE;
      for (int c = 1; c <= 10; c++) tick();
      total++; if (hi !== 32'd2 || lo !== 32'd14)
         $display("FAIL divu got %h:%h exp 00000002:0000000e", hi, lo); else pass_cnt++;
   endtask

   task automatic test_mthi_mtlo();
      start = 1'b1; md_op = MD_MTHI; a = 32'h1234_5678; b = 32'h0;
      #1;
      total++; if (md_stall !== 1'b0) $display("FAIL mthi_stall got %0b exp 0", md_stall); else pass_cnt++;
      tick();
      total++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi got %h exp 12345678", hi); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %0b exp 0", busy); else pass_cnt++;
      md_op = MD_MTLO; a = 32'h9ABC_DEF0;
      tick();
      start = 1'b0; md_op = MD_NONE;
      total++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo_lo got %h exp 9abcdef0", lo); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL mtlo_busy got %0b exp 0", busy); else pass_cnt++;
      // mthi pulsed mid-mult is ignored; 3 * 5 = 15 commits
      start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd5;
      tick();
      start = 1'b0; md_op = MD_NONE;
      tick();
      start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; md_op = MD_NONE;
      total++; if (hi !== 32'h1234_5678) $display("FAIL mthi_busy_ignored got %h exp 12345678", hi); else pass_cnt++;
      total++; if (md_stall !== 1'b1) $display("FAIL stall_busy got %0b exp 1", md_stall); else pass_cnt++;
      tick(); tick(); tick();
      total++; if (hi !== 32'h0 || lo !== 32'd15)
         $display("FAIL mult_after_mthi got %h:%h exp 00000000:0000000f", hi, lo); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; md_op = MD_MTHI; a = 32'hCAFE_0001;
      tick();
      md_op = MD_DIVU; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0; md_op = MD_NONE;
      tick(); tick();
      // now in cycle 3 of the div
      total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %0b exp 1", busy); else pass_cnt++;
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %0b exp 0", busy); else pass_cnt++;
      total++; if (hi !== 32'h0 || lo !== 32'h0)
         $display("FAIL rst_mid_hilo got %h:%h exp 0:0", hi, lo); else pass_cnt++;
      tick(); tick();
      reset = 1'b1;
      for (int c = 0; c < 12; c++) tick();
      total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
         $display("FAIL rst_no_commit got busy %0b %h:%h exp 0 0:0", busy, hi, lo); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int bad;
      // mult 6 * 7 = 42, then divu 1000 / 9 = 111 rem 1 issued in cycle 6
      start = 1'b1; md_op = MD_MULTU; a = 32'd6; b = 32'd7;
      tick();
      start = 1'b0; md_op = MD_NONE;
      bad = 0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 6) begin
            if (hi !== 32'h0 || lo !== 32'd42 || busy !== 1'b0) bad++;
            start = 1'b1; md_op = MD_DIVU; a = 32'd1000; b = 32'd9;
            #1;
         end
         if (md_stall !== 1'b1) bad++;
         tick();
         if (c == 6) begin
            start = 1'b0; md_op = MD_NONE;
         end
      end
      total++; if (bad != 0) $display("FAIL b2b_stall_window bad_cycles %0d exp 0", bad); else pass_cnt++;
      total++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd111)
         $display("FAIL b2b_div got busy %0b %h:%h exp 0 00000001:0000006f", busy, hi, lo); else pass_cnt++;
   endtask

   task automatic test_madd();
      int busy_seen;
      start = 1'b1; md_op = MD_MTHI; a = 32'h0;
      tick();
      md_op = MD_MTLO; a = 32'hFFFF_FFFF;
      tick();
      md_op = MD_MADDU; a = 32'd1; b = 32'd1;
      #1;
`ifdef MULDIV_MADD_EN
      total++; if (md_stall !== 1'b1) $display("FAIL madd_stall got %0b exp 1", md_stall); else pass_cnt++;
`else
      total++; if (md_stall !== 1'b0) $display("FAIL madd_stall got %0b exp 0", md_stall); else pass_cnt++;
`endif
      tick();
      start = 1'b0; md_op = MD_NONE;
      busy_seen = 0;
      for (int c = 1; c <= 5; c++) begin
         if (busy === 1'b1) busy_seen++;
         tick();
      end
`ifdef MULDIV_MADD_EN
      total++; if (busy_seen != 5) $display("FAIL madd_busy got %0d cycles exp 5", busy_seen); else pass_cnt++;
      total++; if (hi !== 32'd1 || lo !== 32'd0)
         $display("FAIL maddu got %h:%h exp 00000001:00000000", hi, lo); else pass_cnt++;
`else
      total++; if (busy_seen != 0) $display("FAIL madd_busy got %0d cycles exp 0", busy_seen); else pass_cnt++;
      total++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF)
         $display("FAIL maddu_off got %h:%h exp 00000000:ffffffff", hi, lo); else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_reset_mid();
      test_back_to_back();
      test_madd();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
